// File: rtl/display_pkg.sv
//------------------------------------------------------------------------------
// display_pkg
// Shared definitions for the 4-digit multiplexed 7-segment scan controller:
// scan state encoding, active-low anode enable constants and small helpers
// that map a digit slot onto its anode pattern and shadow nibble.
//------------------------------------------------------------------------------
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ON   = 2'd2,
      ST_GAP  = 2'd3
   } scan_state_e;

   // Active-low anode enables; DIG0 is the leftmost digit
   localparam logic [3:0] DIGIT_OFF = 4'b1111;
   localparam logic [3:0] DIG0      = 4'b0111;
   localparam logic [3:0] DIG1      = 4'b1011;
   localparam logic [3:0] DIG2      = 4'b1101;
   localparam logic [3:0] DIG3      = 4'b1110;

   // Anode pattern for a digit slot
   function automatic logic [3:0] dig_enable(input logic [1:0] sel);
      logic [3:0] r;
      case (sel)
         2'd0:    r = DIG0;
         2'd1:    r = DIG1;
         2'd2:    r = DIG2;
         2'd3:    r = DIG3;
         default: r = DIGIT_OFF;
      endcase
      return r;
   endfunction

   // Shadow nibble shown in a digit slot, most significant nibble first
   function automatic logic [3:0] nibble_of(input logic [15:0] v, input logic [1:0] sel);
      logic [3:0] r;
      case (sel)
         2'd0:    r = v[15:12];
         2'd1:    r = v[11:8];
         2'd2:    r = v[7:4];
         2'd3:    r = v[3:0];
         default: r = v[3:0];
      endcase
      return r;
   endfunction

   // True when the slot's nibble and all nibbles left of it are zero.
   // The rightmost slot is never considered a leading zero.
   function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] sel);
      logic r;
      case (sel)
         2'd0:    r = (v[15:12] == 4'h0);
         2'd1:    r = (v[15:8] == 8'h00);
         2'd2:    r = (v[15:4] == 12'h000);
         2'd3:    r = 1'b0;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_timer.sv
//------------------------------------------------------------------------------
// scan_slot_timer
// Loadable down-counter timing one scan state. The owning FSM loads the
// state's length on entry; done_o is high in the state's final cycle
// (count == 1). The counter stops at zero and never wraps.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   load_i     load load_val_i this edge (has priority over counting)
//   load_val_i number of cycles the next state lasts
//   done_o     current cycle is the last one of the timed state
//------------------------------------------------------------------------------
module scan_slot_timer #(
   parameter int TW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [TW-1:0] load_val_i,
   output logic          done_o
);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Next count: load, else decrement while non-zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != {TW{1'b0}}) begin
         cnt_d = cnt_q - {{(TW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= {TW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == {{(TW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/display_scan_ctrl.sv
//------------------------------------------------------------------------------
// display_scan_ctrl
// Scan scheduler for a 4-digit multiplexed 7-segment display. A 16-bit value
// is copied into a shadow register only at frame start (LOAD) so a frame
// never mixes two values. Each frame drives the digits left to right for
// ON_CYCLES each, separated by GAP_CYCLES of all-off to prevent ghosting.
// Frame length is 4*(ON_CYCLES+GAP_CYCLES)+1 cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   enable       scan runs while high; a started frame always completes
//   count        value to display, [15:12] = leftmost digit
//   upd_req      request to capture count at the next frame start
//   upd_ack      one-cycle pulse in the LOAD cycle that captured count
//   digit_select active-low anode enables, 4'b1111 = all off
//   mux_o        nibble for the segment decoder (holds outside ON)
//   frame_start  one-cycle pulse in every LOAD cycle
//
// Build option: define SCAN_LZB_EN for leading-zero blanking (leading zero
// digits are switched off; the rightmost digit is always shown).
//------------------------------------------------------------------------------
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int ON_CYCLES  = 49000,
   parameter int GAP_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] count,
   input  logic        upd_req,
   output logic        upd_ack,
   output logic [3:0]  digit_select,
   output logic [3:0]  mux_o,
   output logic        frame_start
);

   localparam int TW = $clog2(((ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES) + 1);
   localparam logic HAS_GAP = (GAP_CYCLES > 0);
   localparam logic [TW-1:0] ON_LEN  = TW'(ON_CYCLES);
   localparam logic [TW-1:0] GAP_LEN = TW'(GAP_CYCLES);

   scan_state_e state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] shadow_q, shadow_d;
   logic [3:0]  digit_select_q, digit_select_d;
   logic [3:0]  mux_q, mux_d;
   logic        upd_ack_q, upd_ack_d;
   logic        frame_start_q, frame_start_d;

   logic          tmr_load_s;
   logic [TW-1:0] tmr_val_s;
   logic          tmr_done_s;

   scan_state_e eos_state_s;
   logic [1:0]  eos_sel_s;
   logic        eos_load_s;

   scan_slot_timer #(
      .TW (TW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load_s),
      .load_val_i (tmr_val_s),
      .done_o     (tmr_done_s)
   );

   // End-of-slot decision: next digit, next frame, or stop after digit 3
   always_comb begin
      eos_state_s = ST_IDLE;
      eos_sel_s   = sel_q;
      eos_load_s  = 1'b0;
      if (sel_q != 2'd3) begin
         eos_state_s = ST_ON;
         eos_sel_s   = sel_q + 2'd1;
         eos_load_s  = 1'b1;
      end else if (enable) begin
         eos_state_s = ST_LOAD;
      end else begin
         eos_state_s = ST_IDLE;
      end
   end

   // Next-state logic and timer loading on state entry
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      tmr_load_s = 1'b0;
      tmr_val_s  = ON_LEN;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_d    = ST_ON;
            sel_d      = 2'd0;
            tmr_load_s = 1'b1;
            tmr_val_s  = ON_LEN;
         end
         ST_ON: begin
            if (tmr_done_s && HAS_GAP) begin
               state_d    = ST_GAP;
               tmr_load_s = 1'b1;
               tmr_val_s  = GAP_LEN;
            end else if (tmr_done_s) begin
               state_d    = eos_state_s;
               sel_d      = eos_sel_s;
               tmr_load_s = eos_load_s;
               tmr_val_s  = ON_LEN;
            end else begin
               state_d = ST_ON;
            end
         end
         ST_GAP: begin
            if (tmr_done_s) begin
               state_d    = eos_state_s;
               sel_d      = eos_sel_s;
               tmr_load_s = eos_load_s;
               tmr_val_s  = ON_LEN;
            end else begin
               state_d = ST_GAP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so the
   // registered outputs line up with the state they belong to
   always_comb begin
      shadow_d       = shadow_q;
      upd_ack_d      = 1'b0;
      frame_start_d  = 1'b0;
      digit_select_d = DIGIT_OFF;
      mux_d          = mux_q;
      case (state_d)
         ST_LOAD: begin
            frame_start_d = 1'b1;
            if (upd_req) begin
               shadow_d  = count;
               upd_ack_d = 1'b1;
            end else begin
               shadow_d  = shadow_q;
            end
         end
         ST_ON: begin
            mux_d = nibble_of(shadow_q, sel_d);
`ifdef SCAN_LZB_EN
            digit_select_d = lz_blank(shadow_q, sel_d) ? DIGIT_OFF : dig_enable(sel_d);
`else
            digit_select_d = dig_enable(sel_d);
`endif
         end
         default: begin
            digit_select_d = DIGIT_OFF;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         sel_q          <= 2'd0;
         shadow_q       <= 16'h0000;
         digit_select_q <= DIGIT_OFF;
         mux_q          <= 4'h0;
         upd_ack_q      <= 1'b0;
         frame_start_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         sel_q          <= sel_d;
         shadow_q       <= shadow_d;
         digit_select_q <= digit_select_d;
         mux_q          <= mux_d;
         upd_ack_q      <= upd_ack_d;
         frame_start_q  <= frame_start_d;
      end
   end

   assign digit_select = digit_select_q;
   assign mux_o        = mux_q;
   assign upd_ack      = upd_ack_q;
   assign frame_start  = frame_start_q;

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Clocked scan scheduler for the 4-digit multiplexed 7-segment display. It snapshots a 16-bit value into a shadow register only at frame boundaries, so the display never tears. It then sequences the digits MSB to LSB with a programmable on-time and an all-off guard gap (anti-ghosting) between digits. It replaces free-running tick-driven digit selection and sits between the debounced counter and the segment decoder.

Parameters:
ON_CYCLES, 49000, clk cycles each digit is driven per slot (must be >= 1)
GAP_CYCLES, 1000, clk cycles all digits are off after each slot (0 = no gap state)
TW, $clog2(max(ON_CYCLES,GAP_CYCLES)+1), slot timer width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
enable  input  1  level; scan runs while high
count  input  16  value to display, nibble [15:12] = leftmost digit
upd_req  input  1  level; request to load count at next frame boundary
upd_ack  output  1  one-cycle pulse: count captured into shadow this cycle
digit_select  output  4  active-low anode enables, 4'b1111 = all off
mux_o  output  4  nibble for the segment decoder
frame_start  output  1  one-cycle pulse at every LOAD

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state IDLE, digit_select 4'b1111, mux_o 4'h0, shadow 16'h0000, sel 0, timer 0, upd_ack 0, frame_start 0.
- Reset mid-operation: abandons the frame; reset values appear after that edge.
- FSM states: IDLE, LOAD, ON, GAP.
- IDLE: digit_select 1111. If enable=1 at an edge, go to LOAD.
- LOAD (exactly 1 cycle):
  - frame_start=1; sel<=0.
  - If upd_req=1: shadow<=count and upd_ack=1 in this cycle. Otherwise shadow holds.
  - Next state is ON.
- ON: lasts exactly ON_CYCLES cycles.
  - digit_select by sel: 0→0111, 1→1011, 2→1101, 3→1110.
  - mux_o = shadow nibble by sel: 0→[15:12], 1→[11:8], 2→[7:4], 3→[3:0].
  - Exit to GAP, or straight to the end-of-slot decision if GAP_CYCLES=0.
- GAP: lasts exactly GAP_CYCLES cycles. digit_select 1111; mux_o holds its last value.
- End of slot:
  - sel<3: sel++ and go to ON.
  - sel==3 and enable=1: go to LOAD.
  - sel==3 and enable=0: go to IDLE.
- Latency: enable sampled high in IDLE at edge k → LOAD after edge k → first ON (0111) after edge k+1.
- Frame length = 4*(ON_CYCLES+GAP_CYCLES)+1 cycles.
- enable dropping mid-frame: the frame completes all four slots, then goes to IDLE. No partial frames.
- count changes with upd_req=0 have no effect. The shadow changes only in LOAD.
- upd_req held high: the shadow reloads every frame, with one upd_ack per frame.
- upd_req falling before LOAD: no capture and no ack.
- Timer: a down-counter loaded on state entry; the state exits when it reaches 1. It never wraps.

Optional Feature:
Macro: SCAN_LZB_EN (leading-zero blanking).
- With the macro: in ON, a digit is blanked (digit_select=1111) when sel<3 and it and every higher nibble of the shadow are zero.
  - Slot timing and mux_o are unchanged.
  - sel==3 is never blanked.
- Without the macro: all four digits are always driven.

Decomposition:
- Shared package display_pkg:
  - scan state enum (IDLE, LOAD, ON, GAP)
  - DIGIT_OFF = 4'b1111
  - digit-enable constants DIG0..DIG3 (0111, 1011, 1101, 1110)
- One natural sub-module: scan_slot_timer, a loadable TW-bit down-counter with a done flag, instantiated once.

Test Plan:
Use ON_CYCLES=4, GAP_CYCLES=2 unless stated.
- Reset → idle: reset 3 cycles with enable=0 → digit_select=1111, mux_o=0, upd_ack=0, frame_start=0 held for 20 cycles.
- Scan order: count=16'h1234, upd_req=1, enable=1 → upd_ack pulses once in LOAD. Then (0111,1)×4, 1111×2, (1011,2)×4, 1111×2, (1101,3)×4, 1111×2, (1110,4)×4, 1111×2. frame_start recurs every 25 cycles.
- No tearing: drop upd_req, set count=16'hABCD mid-frame → display stays 1234 for following frames. Raise upd_req → ABCD appears from the next LOAD, with one upd_ack.
- Enable drop: deassert enable during sel=1 ON → slots 2 and 3 still complete, then IDLE with digit_select=1111 and no frame_start.
- Reset mid-ON (sel=2) → after that edge digit_select=1111, shadow=0. Re-enable → LOAD then 0111 with mux_o=0.
- SCAN_LZB_EN defined:
  - count=16'h0045 → slots 0 and 1 show 1111, slots 2 and 3 show 4 and 5.
  - count=16'h0000 → only 1110 with mux_o=0.
  - Macro undefined → all four digits shown.
  - Extra run with GAP_CYCLES=0 → frame length 17 cycles and no 1111 between digits.
